cpu_irq_claim: RTL and testbench

CPU_IRQ_CLAIM -- requirements
Module: cpu_irq_claim

---
 rtl/cpu_irq_claim.sv | 173 +++++++++++++++++
 tb/tb_cpu_irq_claim.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_irq_claim.sv
// Interrupt claim/complete sequencer: claims a source from the interrupt controller over the bus,
// traps the core, and writes the ID back on completion. Define CPU_IRQ_CLAIM_TIMEOUT_EN for a bus timeout.
module cpu_irq_claim #(
    parameter logic [23:0] CLAIM_ADDRESS  = 24'h200004,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_interrupt,
    input  logic        i_enable,
    output logic        o_irq,
    output logic [31:0] o_irq_id,
    input  logic        i_irq_ack,
    input  logic        i_complete,
    output logic        o_request,
    output logic        o_rw,
    output logic [23:0] o_address,
    output logic [31:0] o_wdata,
    input  logic [31:0] i_rdata,
    input  logic        i_ready,
    output logic        o_bus_error
);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StClaim    = 3'd1;
    localparam logic [2:0] StTrap     = 3'd2;
    localparam logic [2:0] StActive   = 3'd3;
    localparam logic [2:0] StComplete = 3'd4;
    localparam logic [2:0] StGap      = 3'd5;

    logic [2:0]  state_q, state_d;
    logic        request_q, request_d;
    logic        rw_q, rw_d;
    logic [23:0] address_q, address_d;
    logic [31:0] wdata_q, wdata_d;
    logic        irq_q, irq_d;
    logic [31:0] irq_id_q, irq_id_d;
    logic        bus_error_q, bus_error_d;
    logic        release_bus;
    logic        timeout;

`ifdef CPU_IRQ_CLAIM_TIMEOUT_EN
    logic [7:0] count_q, count_d;

    // Counter idles at zero, so every new request starts counting from scratch.
    assign count_d = request_q ? count_q + 8'd1 : 8'd0;
    assign timeout = request_q && ((32'(count_q) + 32'd1) >= TIMEOUT_CYCLES);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        request_d   = request_q;
        rw_d        = rw_q;
        address_d   = address_q;
        wdata_d     = wdata_q;
        irq_d       = irq_q;
        irq_id_d    = irq_id_q;
        bus_error_d = 1'b0;
        release_bus = 1'b0;

        case (state_q)
            StIdle: begin
                if (i_interrupt && i_enable) begin
                    state_d   = StClaim;
                    request_d = 1'b1;
                    rw_d      = 1'b0;
                    address_d = CLAIM_ADDRESS;
                    wdata_d   = 32'd0;
                end
            end
            StClaim: begin
                if (i_ready) begin
                    release_bus = 1'b1;
                    if (i_rdata != 32'd0) begin
                        irq_id_d = i_rdata;
                        irq_d    = 1'b1;
                        state_d  = StTrap;
                    end else begin
                        state_d = StGap;
                    end
                end else if (timeout) begin
                    release_bus = 1'b1;
                    bus_error_d = 1'b1;
                    state_d     = StGap;
                end
            end
            StTrap: begin
                if (i_irq_ack) begin
                    irq_d   = 1'b0;
                    state_d = StActive;
                end
            end
            StActive: begin
                // Pending interrupts wait here; only completion moves us on.
                if (i_complete) begin
                    state_d   = StComplete;
                    request_d = 1'b1;
                    rw_d      = 1'b1;
                    address_d = CLAIM_ADDRESS;
                    wdata_d   = irq_id_q;
                end
            end
            StComplete: begin
                if (i_ready) begin
                    release_bus = 1'b1;
                    state_d     = StGap;
                end else if (timeout) begin
                    release_bus = 1'b1;
                    bus_error_d = 1'b1;
                    state_d     = StGap;
                end
            end
            StGap: begin
                state_d  = StIdle;
                irq_id_d = 32'd0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (release_bus) begin
            request_d = 1'b0;
            rw_d      = 1'b0;
            address_d = 24'd0;
            wdata_d   = 32'd0;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= StIdle;
            request_q   <= 1'b0;
            rw_q        <= 1'b0;
            address_q   <= 24'd0;
            wdata_q     <= 32'd0;
            irq_q       <= 1'b0;
            irq_id_q    <= 32'd0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            request_q   <= request_d;
            rw_q        <= rw_d;
            address_q   <= address_d;
            wdata_q     <= wdata_d;
            irq_q       <= irq_d;
            irq_id_q    <= irq_id_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign o_request   = request_q;
    assign o_rw        = rw_q;
    assign o_address   = address_q;
    assign o_wdata     = wdata_q;
    assign o_irq       = irq_q;
    assign o_irq_id    = irq_id_q;
    assign o_bus_error = bus_error_q;

endmodule

// File: tb/tb_cpu_irq_claim.sv
// Self-checking bench for cpu_irq_claim: per-cycle vector table plus directed reset/stall/timeout sequences.
module tb_cpu_irq_claim;

    localparam logic [23:0] A = 24'h200004;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_interrupt = 1'b0;
    logic        i_enable = 1'b0;
    logic        i_irq_ack = 1'b0;
    logic        i_complete = 1'b0;
    logic [31:0] i_rdata = 32'd0;
    logic        i_ready = 1'b0;
    logic        o_irq;
    logic [31:0] o_irq_id;
    logic        o_request;
    logic        o_rw;
    logic [23:0] o_address;
    logic [31:0] o_wdata;
    logic        o_bus_error;

    int checks = 0;
    int errors = 0;

    cpu_irq_claim dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_interrupt (i_interrupt),
        .i_enable    (i_enable),
        .o_irq       (o_irq),
        .o_irq_id    (o_irq_id),
        .i_irq_ack   (i_irq_ack),
        .i_complete  (i_complete),
        .o_request   (o_request),
        .o_rw        (o_rw),
        .o_address   (o_address),
        .o_wdata     (o_wdata),
        .i_rdata     (i_rdata),
        .i_ready     (i_ready),
        .o_bus_error (o_bus_error)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic        intr;
        logic        en;
        logic        ack;
        logic        cmp;
        logic        rdy;
        logic [31:0] rdata;
        logic        req;
        logic        rw;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic        irq;
        logic [31:0] id;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic intr, input logic en, input logic ack, input logic cmp,
                                input logic rdy, input logic [31:0] rdata, input logic req,
                                input logic rw, input logic [23:0] addr, input logic [31:0] wdata,
                                input logic irq, input logic [31:0] id);
        vec_t v;
        v.intr = intr; v.en = en; v.ack = ack; v.cmp = cmp; v.rdy = rdy; v.rdata = rdata;
        v.req = req; v.rw = rw; v.addr = addr; v.wdata = wdata; v.irq = irq; v.id = id;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic intr, input logic en, input logic ack, input logic cmp,
                         input logic rdy, input logic [31:0] rdata);
        @(negedge i_clock);
        i_interrupt = intr; i_enable = en; i_irq_ack = ack; i_complete = cmp;
        i_ready = rdy; i_rdata = rdata;
        @(posedge i_clock);
        #1;
    endtask

    logic [91:0] act_v, exp_v;
    int hi, be;

    initial begin
        // Transfer, ignored-strobe, spurious, back-to-back and completion-wins scenarios.
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,            1, 0, A, 0,            0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,            1, 0, A, 0,            0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 3,            0, 0, 0, 0,            1, 3));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,            0, 0, 0, 0,            1, 3));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0,            0, 0, 0, 0,            0, 3));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0,            0, 0, 0, 0,            0, 3));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,            1, 1, A, 3,            0, 3));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0,            0, 0, 0, 0,            0, 3));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,            0, 0, 0, 0,            0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,            1, 0, A, 0,            0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0,            0, 0, 0, 0,            0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,            0, 0, 0, 0,            0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0,            0, 0, 0, 0,            0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,            1, 0, A, 0,            0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 0,            0, 0, 0, 0,            0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,            0, 0, 0, 0,            0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,            1, 0, A, 0,            0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h80000001, 0, 0, 0, 0,            1, 32'h80000001));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0,            0, 0, 0, 0,            0, 32'h80000001));
        vecs.push_back(mk(1, 1, 0, 1, 0, 0,            1, 1, A, 32'h80000001, 0, 32'h80000001));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,            1, 1, A, 32'h80000001, 0, 32'h80000001));
        vecs.push_back(mk(1, 1, 0, 0, 1, 0,            0, 0, 0, 0,            0, 32'h80000001));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,            0, 0, 0, 0,            0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,            1, 0, A, 0,            0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0,            0, 0, 0, 0,            0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,            0, 0, 0, 0,            0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'hffff,     0, 0, 0, 0,            0, 0));

        repeat (2) @(posedge i_clock);
        #1;
        act_v = {o_request, o_rw, o_address, o_wdata, o_irq, o_irq_id, o_bus_error};
        checks++;
        if (act_v !== 92'd0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0", act_v);
        end
        @(negedge i_clock);
        i_reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].intr, vecs[i].en, vecs[i].ack, vecs[i].cmp, vecs[i].rdy, vecs[i].rdata);
            act_v = {o_request, o_rw, o_address, o_wdata, o_irq, o_irq_id, o_bus_error};
            exp_v = {vecs[i].req, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].irq, vecs[i].id,
                     1'b0};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL vec%0d: got %h expected %h", i, act_v, exp_v);
            end
        end

        // Interrupt pending but globally disabled: no claim until enable rises.
        for (int k = 0; k < 20; k++) begin
            drive(1, 0, 0, 0, 0, 0);
            check("disabled_no_request", {31'd0, o_request}, 32'd0);
        end
        drive(1, 1, 0, 0, 0, 0);
        check("enable_rise_request", {31'd0, o_request}, 32'd1);

        // Slow responder: request fields must hold until ready.
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 0, 0, 0, 0);
            check("stall_hold", {6'd0, o_request, o_rw, o_address}, {6'd0, 1'b1, 1'b0, A});
        end
        drive(0, 1, 0, 0, 1, 0);
        check("stall_drop", {31'd0, o_request}, 32'd0);
        drive(0, 1, 0, 0, 0, 0);
        check("stall_gap", {31'd0, o_request}, 32'd0);

        // Reset in the middle of a claim read.
        drive(1, 1, 0, 0, 0, 0);
        check("claim_before_reset", {31'd0, o_request}, 32'd1);
        #2 i_reset = 1'b1;
        #1 check("reset_in_claim", {30'd0, o_request, o_irq}, 32'd0);
        @(negedge i_clock);
        i_reset = 1'b0;
        i_interrupt = 1'b0;

        // Reset in the middle of a complete write.
        drive(1, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 1, 5);
        check("claim5_irq", o_irq_id, 32'd5);
        drive(0, 1, 1, 0, 0, 0);
        drive(0, 1, 0, 1, 0, 0);
        check("complete5_write", {o_request, o_rw, 6'd0, o_address}, {1'b1, 1'b1, 6'd0, A});
        #2 i_reset = 1'b1;
        #1 check("reset_in_complete", {o_request, o_irq, 30'd0}, 32'd0);
        check("reset_clears_id", o_irq_id, 32'd0);
        @(negedge i_clock);
        i_reset = 1'b0;
        i_interrupt = 1'b0;
        i_complete = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 1, 1, 0, 0);
            check("no_write_after_reset", {31'd0, o_request}, 32'd0);
        end
        drive(1, 1, 0, 0, 0, 0);
        check("first_claim_after_reset", {31'd0, o_request}, 32'd1);

`ifdef CPU_IRQ_CLAIM_TIMEOUT_EN
        hi = 1;
        be = 0;
        for (int k = 0; k < 300; k++) begin
            drive(0, 1, 0, 0, 0, 0);
            if (o_request) hi++;
            if (o_bus_error) be++;
        end
        check("timeout_request_cycles", hi, 32'd255);
        check("timeout_bus_error_pulses", be, 32'd1);
        drive(1, 1, 0, 0, 0, 0);
        check("idle_after_timeout", {31'd0, o_request}, 32'd1);
        drive(0, 1, 0, 0, 1, 0);
`else
        hi = 1;
        be = 0;
        for (int k = 0; k < 300; k++) begin
            drive(0, 1, 0, 0, 0, 0);
            if (o_request) hi++;
            if (o_bus_error) be++;
        end
        check("no_timeout_request_held", hi, 32'd301);
        check("no_timeout_bus_error", be, 32'd0);
        drive(0, 1, 0, 0, 1, 0);
`endif
        check("final_release", {31'd0, o_request}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
